imem_boot_loader: RTL and testbench

Sits directly upstream of the RISC-V pipeline core. Receives a byte stream over a valid/ready channel and assembles little-endian 32-bit instruction words. Writes those words into instruction memory starting at word address 0. Holds the core in reset until the image is fully loaded, then releases it.

---
 rtl/boot_pkg.sv | 32 +++
 rtl/boot_word_assembler.sv | 49 ++++
 rtl/imem_boot_loader.sv | 153 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// ---------------------------------------------------------------------------
// boot_pkg
// Shared definitions for the instruction-memory boot loader.
//   boot_state_e : loader FSM states (LEN, DATA, CHK, RUN, ERROR)
//   BYTE_CNT_W   : width of the byte-lane counter inside a 32-bit word
//   BYTE_W/WORD_W: byte and instruction-word widths
//   LANE_FIRST/LANE_LAST : little-endian lane indices (lane 0 = bits 7:0)
// CHK is only reachable when BOOT_CHECKSUM_EN is defined.
// ---------------------------------------------------------------------------
package boot_pkg;

  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_DATA  = 3'd1,
    ST_CHK   = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } boot_state_e;

  localparam int BYTE_CNT_W = 2;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 32;

  localparam logic [BYTE_CNT_W-1:0] LANE_FIRST = 2'd0;
  localparam logic [BYTE_CNT_W-1:0] LANE_LAST  = 2'd3;

  // States in which the loader is willing to accept stream bytes.
  function automatic logic accepts_bytes(input boot_state_e s);
    return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/boot_word_assembler.sv
// ---------------------------------------------------------------------------
// boot_word_assembler
// Collects four bytes into a little-endian 32-bit word (first byte -> 7:0).
// Ports:
//   clk          : system clock
//   clear_i      : synchronous clear of lane counter and shift register
//   byte_i       : incoming byte, consumed when strobe_i is high
//   strobe_i     : byte-accept strobe
//   word_o       : assembled word, valid while word_valid_o is high
//   word_valid_o : high for the strobe that delivers the 4th byte
// ---------------------------------------------------------------------------
module boot_word_assembler
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              clear_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              strobe_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o
);

  logic [BYTE_CNT_W-1:0] lane_q, lane_d;
  logic [WORD_W-1:0]     shreg_q, shreg_d;

  always_comb begin
    lane_d  = lane_q;
    shreg_d = shreg_q;
    if (clear_i) begin
      lane_d  = LANE_FIRST;
      shreg_d = '0;
    end else if (strobe_i) begin
      lane_d  = lane_q + BYTE_CNT_W'(1);
      // Shift right so the first byte ends up in the low lane after 4 shifts.
      shreg_d = {byte_i, shreg_q[WORD_W-1:BYTE_W]};
    end
  end

  always_ff @(posedge clk) begin
    lane_q  <= lane_d;
    shreg_q <= shreg_d;
  end

  // The word is presented combinationally on the 4th byte so the top can
  // register it on the same edge that accepts that byte.
  assign word_o       = {byte_i, shreg_q[WORD_W-1:BYTE_W]};
  assign word_valid_o = strobe_i && !clear_i && (lane_q == LANE_LAST);

endmodule

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Receives a boot image over a byte valid/ready channel, writes it into
// instruction memory from word address 0, and holds the core in reset until
// the image is loaded.
// Image: 4-byte LE word count N, then N LE words.
// Optional macro BOOT_CHECKSUM_EN: one trailing byte equal to the XOR of all
// length and data bytes; mismatch rejects the image.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   rx_data/rx_valid/rx_ready : byte stream input
//   imem_we/imem_addr/imem_wdata : one-cycle write strobe to instruction memory
//   core_reset   : core reset, high until the image is loaded
//   boot_done    : image accepted, core released
//   boot_error   : image rejected, core kept in reset
//   words_loaded : number of words written so far
// ---------------------------------------------------------------------------
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int IMEM_DEPTH = 1024,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              boot_done,
  output logic              boot_error,
  output logic [ADDR_W:0]   words_loaded
);

`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_e ST_AFTER_DATA = ST_CHK;
`else
  localparam boot_state_e ST_AFTER_DATA = ST_RUN;
`endif

  boot_state_e       state_q, state_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              core_reset_q, core_reset_d;
  logic              boot_done_q, boot_done_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  logic        xfer;
  logic        asm_strobe;
  logic        word_valid;
  logic [31:0] word;

  assign rx_ready   = !reset && accepts_bytes(state_q);
  assign xfer       = rx_valid && rx_ready;
  assign asm_strobe = xfer && ((state_q == ST_LEN) || (state_q == ST_DATA));

  boot_word_assembler u_asm (
    .clk          (clk),
    .clear_i      (reset),
    .byte_i       (rx_data),
    .strobe_i     (asm_strobe),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    words_d      = words_q;
    len_d        = len_q;
    // Release lags RUN entry by one edge so the final write strobe has
    // already retired when the core leaves reset.
    core_reset_d = (state_q != ST_RUN);
    boot_done_d  = (state_q == ST_RUN);
`ifdef BOOT_CHECKSUM_EN
    xor_d        = xor_q;
    if (asm_strobe) xor_d = xor_q ^ rx_data;
`endif

    case (state_q)
      ST_LEN: begin
        if (word_valid) begin
          len_d = word[ADDR_W:0];
          if (word > 32'(IMEM_DEPTH)) state_d = ST_ERROR;
          else if (word == '0)        state_d = ST_AFTER_DATA;
          else                        state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_valid) begin
          imem_we_d = 1'b1;
          addr_d    = words_q[ADDR_W-1:0];
          wdata_d   = word;
          words_d   = words_q + (ADDR_W+1)'(1);
          if (words_d == len_q) state_d = ST_AFTER_DATA;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      ST_CHK: begin
        if (xfer) state_d = (rx_data == xor_q) ? ST_RUN : ST_ERROR;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_LEN;
      imem_we_q    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      words_q      <= '0;
      len_q        <= '0;
      core_reset_q <= 1'b1;
      boot_done_q  <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      imem_we_q    <= imem_we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      words_q      <= words_d;
      len_q        <= len_d;
      core_reset_q <= core_reset_d;
      boot_done_q  <= boot_done_d;
`ifdef BOOT_CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  assign imem_we      = imem_we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign words_loaded = words_q;
  assign core_reset   = core_reset_q;
  assign boot_done    = boot_done_q;
  assign boot_error   = (state_q == ST_ERROR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
// Scoreboard bench: each image pushes its expected memory writes into a
// queue; a negedge monitor pops and compares on every imem_we strobe.
// Honors BOOT_CHECKSUM_EN when compiled with it.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

  localparam int IMEM_DEPTH = 1024;
  localparam int ADDR_W     = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              boot_done;
  logic              boot_error;
  logic [ADDR_W:0]   words_loaded;

  imem_boot_loader #(.IMEM_DEPTH(IMEM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_reset   (core_reset),
    .boot_done    (boot_done),
    .boot_error   (boot_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation,
  // and the core must still be held in reset while it happens.
  always @(negedge clk) begin
    wr_t e;
    if (imem_we) begin
      $display("write addr=%0d data=%08h", imem_addr, imem_wdata);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(imem_we), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(imem_addr), 64'(e.addr));
        check("wr_data", 64'(imem_wdata), 64'(e.data));
        check("core_reset_during_write", 64'(core_reset), 64'(1));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All stimulus tasks start and end at #1 after a rising edge.
  // gap < 0: exactly one idle cycle before each byte; else percent idle chance.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap < 0) begin
      rx_valid = 1'b0; @(posedge clk); #1;
    end else begin
      while (int'($urandom_range(99)) < gap) begin
        rx_valid = 1'b0; rx_data = 8'($urandom); @(posedge clk); #1;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    @(negedge clk);
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) check("rx_ready_timeout", 64'(rx_ready), 64'(1));
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_rx_ready", 64'(rx_ready), 64'(0));
    check("rst_imem_we", 64'(imem_we), 64'(0));
    check("rst_imem_addr", 64'(imem_addr), 64'(0));
    check("rst_imem_wdata", 64'(imem_wdata), 64'(0));
    check("rst_words_loaded", 64'(words_loaded), 64'(0));
    check("rst_core_reset", 64'(core_reset), 64'(1));
    check("rst_boot_done", 64'(boot_done), 64'(0));
    check("rst_boot_error", 64'(boot_error), 64'(0));
    exp_q.delete();
    reset    = 1'b0;
    rx_valid = 1'b0;
    #1;
    check("post_rst_rx_ready", 64'(rx_ready), 64'(1));
  endtask

  // Reference model: the image is accepted iff N fits the memory (and, with
  // the checksum, the trailing byte equals the XOR of all preceding bytes).
  task automatic run_image(input logic [31:0] n, input logic [31:0] words[$],
                           input int gap, input logic [7:0] chk_delta);
    logic [7:0]  csum;
    logic [31:0] w;
    bit          len_err;
    bit          ok;
    wr_t         e;
    csum    = 8'h00;
    len_err = (n > 32'(IMEM_DEPTH));
    ok      = !len_err;
`ifdef BOOT_CHECKSUM_EN
    ok = ok && (chk_delta == 8'h00);
`endif
    $display("image n=%0d gap=%0d chk_delta=%0h expect=%s", n, gap, chk_delta, ok ? "done" : "error");
    if (!len_err) begin
      for (int i = 0; i < int'(n); i++) begin
        e.addr = ADDR_W'(i);
        e.data = words[i];
        exp_q.push_back(e);
      end
    end
    for (int k = 0; k < 4; k++) begin
      send_byte(n[8*k +: 8], gap);
      csum ^= n[8*k +: 8];
    end
    if (!len_err) begin
      for (int i = 0; i < int'(n); i++) begin
        w = words[i];
        for (int k = 0; k < 4; k++) begin
          send_byte(w[8*k +: 8], gap);
          csum ^= w[8*k +: 8];
        end
      end
`ifdef BOOT_CHECKSUM_EN
      send_byte(csum ^ chk_delta, gap);
`endif
    end
    if (ok) begin
      check("core_reset_before_release", 64'(core_reset), 64'(1));
      @(posedge clk); #1;
      check("core_reset_release", 64'(core_reset), 64'(0));
      check("boot_done_release", 64'(boot_done), 64'(1));
    end
    // Keep offering bytes: a finished loader must refuse them and write nothing.
    rx_valid = 1'b1;
    rx_data  = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("end_rx_ready", 64'(rx_ready), 64'(0));
    check("end_boot_done", 64'(boot_done), 64'(ok));
    check("end_boot_error", 64'(boot_error), 64'(!ok));
    check("end_core_reset", 64'(core_reset), 64'(!ok));
    check("end_words_loaded", 64'(words_loaded), 64'(len_err ? 32'd0 : n));
    check("end_writes_pending", 64'(exp_q.size()), 64'(0));
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] wq[$];
    logic [31:0] n;
    logic [7:0]  d;

    do_reset();

    // Directed: two-word program, continuous and with idle cycles.
    wq = '{32'h00500513, 32'h00A00593};
    run_image(32'd2, wq, 0, 8'h00);
    do_reset();
    run_image(32'd2, wq, -1, 8'h00);
    do_reset();

    // Empty image and over-long image.
    wq.delete();
    run_image(32'd0, wq, 0, 8'h00);
    do_reset();
    run_image(32'd1025, wq, 0, 8'h00);
    do_reset();

    // Reset in the middle of a word, then a clean reload from address 0.
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h13, 0); send_byte(8'h05, 0);
    rx_valid = 1'b1;
    do_reset();
    wq = '{32'h00500513, 32'h00A00593};
    run_image(32'd2, wq, 0, 8'h00);
    do_reset();

`ifdef BOOT_CHECKSUM_EN
    run_image(32'd2, wq, 0, 8'h01);
    do_reset();
`endif

    // Largest legal image fills the memory.
    wq.delete();
    for (int i = 0; i < IMEM_DEPTH; i++) wq.push_back($urandom);
    run_image(32'(IMEM_DEPTH), wq, 0, 8'h00);
    do_reset();

    // Random images with random gaps, lengths and (optionally) bad checksums.
    for (int it = 0; it < 25; it++) begin
      wq.delete();
      if ($urandom_range(9) < 8) n = 32'($urandom_range(0, 6));
      else if ($urandom_range(1) == 0) n = 32'(IMEM_DEPTH + 1) + 32'($urandom_range(0, 5000));
      else n = $urandom | 32'h8000_0000;
      for (int i = 0; i < 6; i++) wq.push_back($urandom);
      d = ($urandom_range(4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_image(n, wq, int'($urandom_range(0, 60)), d);
      do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
